// File: rtl/e_mdu_pkg.sv
// Shared E-stage MDU definitions: operation encodings, default latencies and FSM states.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: 64-bit products and quotient/remainder for the issued op.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
    logic               sgn_div;
    logic               neg1;
    logic               neg2;
    logic [31:0]        mag1;
    logic [31:0]        mag2;
    logic [31:0]        divisor;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        sq;
    logic [31:0]        sr;

    always_comb begin
        s_prod   = $signed({{32{in1[31]}}, in1}) * $signed({{32{in2[31]}}, in2});
        u_prod   = {32'd0, in1} * {32'd0, in2};
        div_zero = (in2 == 32'd0);

        // Signed divide runs on magnitudes; INT_MIN/-1 falls out as |q|=0x80000000 negated to itself, r=0.
        sgn_div = (op == MDU_DIV);
        neg1    = sgn_div & in1[31];
        neg2    = sgn_div & in2[31];
        mag1    = neg1 ? (32'd0 - in1) : in1;
        mag2    = neg2 ? (32'd0 - in2) : in2;
        divisor = div_zero ? 32'd1 : mag2;
        uq      = mag1 / divisor;
        ur      = mag1 % divisor;
        sq      = (neg1 ^ neg2) ? (32'd0 - uq) : uq;
        sr      = neg1 ? (32'd0 - ur) : ur;

        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MDU_MULT:  {hi, lo} = s_prod;
            MDU_MULTU: {hi, lo} = u_prod;
            MDU_DIV,
            MDU_DIVU: begin
                hi = sr;
                lo = sq;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | cnt==0, busy=0; accepts mult/div issue and mthi/mtlo writes
//   ST_RUN  | cnt>0, busy=1; counting down, HI/LO loaded when cnt reaches 1
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] MDUIn1,
    input  logic [31:0] MDUIn2,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDURes
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    mdu_state_e  state;
    mdu_state_e  state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [31:0] pend_hi_nxt;
    logic [31:0] pend_lo_nxt;
    logic        pend_skip;
    logic        pend_skip_nxt;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div_zero;

    e_mdu_calc u_calc (
        .op       (MDUOp),
        .in1      (MDUIn1),
        .in2      (MDUIn2),
        .hi       (calc_hi),
        .lo       (calc_lo),
        .div_zero (calc_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
            pend_hi   <= pend_hi_nxt;
            pend_lo   <= pend_lo_nxt;
            pend_skip <= pend_skip_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hi_nxt        = hi_q;
        lo_nxt        = lo_q;
        pend_hi_nxt   = pend_hi;
        pend_lo_nxt   = pend_lo;
        pend_skip_nxt = pend_skip;

        case (state)
            ST_IDLE: begin
                if (!req) begin
                    if (start && is_muldiv(MDUOp)) begin
                        pend_hi_nxt   = calc_hi;
                        pend_lo_nxt   = calc_lo;
                        // A zero divisor still occupies the unit but must leave HI/LO intact.
                        pend_skip_nxt = !is_mult(MDUOp) && calc_div_zero;
                        cnt_nxt       = is_mult(MDUOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state_nxt     = ST_RUN;
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_nxt = MDUIn1;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_nxt = MDUIn1;
                    end
                end
            end
            ST_RUN: begin
                if (cnt == CW'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                    if (!pend_skip) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDURes = 32'd0;
        if (MDUOp == MDU_MFHI)      MDURes = hi_q;
        else if (MDUOp == MDU_MFLO) MDURes = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: issued ops push expected HI/LO/latency, a monitor checks on busy fall.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] MDUIn1;
    logic [31:0] MDUIn2;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDURes;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    e_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .start  (start),
        .MDUOp  (MDUOp),
        .MDUIn1 (MDUIn1),
        .MDUIn2 (MDUIn2),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDURes (MDURes)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour from the architectural definitions, using 64-bit integer arithmetic.
    function automatic exp_t ref_op(input int op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] cur_hi, input logic [31:0] cur_lo);
        exp_t e;
        int ia, ib;
        longint sa, sb, sr;
        longint unsigned ua, ub, ur;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = a;
        ub = b;
        e.hi = cur_hi;
        e.lo = cur_lo;
        e.cycles = (op <= 2) ? 5 : 10;
        case (op)
            1: begin sr = sa * sb; e.hi = sr[63:32]; e.lo = sr[31:0]; end
            2: begin ur = ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; end
            3: if (b != 0) begin
                   sr = sa / sb; e.lo = sr[31:0];
                   sr = sa % sb; e.hi = sr[31:0];
               end
            4: if (b != 0) begin e.lo = a / b; e.hi = a % b; end
            default: ;
        endcase
        return e;
    endfunction

    logic mon_prev = 1'b0;
    int   mon_len  = 0;
    always @(negedge clk) begin
        if (reset) begin
            mon_prev = 1'b0;
            mon_len  = 0;
        end else begin
            if (busy) begin
                mon_len++;
            end else if (mon_prev) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got completion expected none queued");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("busy_cycles", 32'(mon_len), 32'(e.cycles));
                    chk("hi_result", HI, e.hi);
                    chk("lo_result", LO, e.lo);
                end
                mon_len = 0;
            end
            mon_prev = busy;
        end
    end

    function automatic logic [31:0] res_exp(input logic [3:0] op);
        if (op == 4'd5) return m_hi;
        if (op == 4'd6) return m_lo;
        return 32'd0;
    endfunction

    // Called right after a negedge; returns right after the negedge where busy has fallen.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bit   done;
        start  = 1'b1;
        MDUOp  = 4'(op);
        MDUIn1 = a;
        MDUIn2 = b;
        e = ref_op(op, a, b, m_hi, m_lo);
        sb_q.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        MDUIn1 = $urandom;
        MDUIn2 = $urandom;
        done   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            chk("mdures_busy", MDURes, res_exp(MDUOp));
            MDUOp  = 4'($urandom_range(5, 8));
            MDUIn1 = $urandom;
            @(negedge clk);
        end
        MDUOp = 4'd0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: got busy stuck expected release");
        end
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic idle_check(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_hi"}, HI, m_hi);
        chk({name, "_lo"}, LO, m_lo);
    endtask

    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        start  = 1'b0;
        MDUOp  = 4'd5;
        MDUIn1 = 32'd0;
        MDUIn2 = 32'd0;
        repeat (2) @(negedge clk);
        idle_check("reset");
        chk("reset_mdures", MDURes, 32'd0);
        reset = 1'b0;
        MDUOp = 4'd0;
        @(negedge clk);

        issue(1, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_dir_hi", m_hi, 32'hFFFF_FFFF);
        issue(2, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("multu_dir_hi", m_hi, 32'h0000_0001);
        issue(3, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_dir_lo", m_lo, 32'hFFFF_FFFD);
        issue(4, 32'd7, 32'd0);
        issue(3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_lo", m_lo, 32'h8000_0000);
        chk("div_min_hi", m_hi, 32'd0);

        MDUOp  = 4'd7;
        MDUIn1 = 32'h0000_1234;
        @(negedge clk);
        m_hi  = 32'h0000_1234;
        MDUOp = 4'd5;
        #1;
        chk("mthi_mfhi", MDURes, 32'h0000_1234);
        MDUOp  = 4'd8;
        MDUIn1 = 32'hDEAD_BEEF;
        req    = 1'b1;
        @(negedge clk);
        idle_check("mtlo_req");
        MDUOp = 4'd1;
        start = 1'b1;
        @(negedge clk);
        idle_check("start_req");
        @(negedge clk);
        idle_check("start_req2");
        req   = 1'b0;
        start = 1'b0;
        MDUOp = 4'd0;

        start  = 1'b1;
        MDUOp  = 4'd3;
        MDUIn1 = 32'd100;
        MDUIn2 = 32'd3;
        sb_q.push_back(ref_op(3, 32'd100, 32'd3, m_hi, m_lo));
        @(negedge clk);
        start = 1'b0;
        MDUOp = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        idle_check("reset_mid");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            int op;
            logic [31:0] a, b;
            op = $urandom_range(1, 4);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 9));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            issue(op, a, b);
            if ($urandom_range(0, 3) == 0) begin
                logic [31:0] v;
                v      = $urandom;
                req    = 1'($urandom_range(0, 1));
                MDUOp  = 4'($urandom_range(7, 8));
                MDUIn1 = v;
                @(negedge clk);
                if (!req) begin
                    if (MDUOp == 4'd7) m_hi = v;
                    else               m_lo = v;
                end
                req   = 1'b0;
                MDUOp = 4'd0;
                idle_check("rand_mt");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
